// File: rtl/icache_pkg.sv
// Shared constants for the instruction-cache refill path.
// Holds FSM state codes, word offset and default widths.
package icache_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_LAT_W  = 8;
   localparam int DEF_CNT_W  = 20;
   localparam int WORD_OFS   = 2;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t REQ  = 2'd1;
   localparam state_t WAIT = 2'd2;
   localparam state_t FILL = 2'd3;

endpackage

// File: rtl/icache_refill_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Exposes only the saturated increment of the held count.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         Clr,
   input  logic         Inc,
   output logic [W-1:0] Count_Next
);

   logic [W-1:0] count;

   assign Count_Next = (&count) ? count : count + W'(1);

   always_ff @(posedge CLK) begin
      if (RESET || Clr)
         count <= '0;
      else if (Inc)
         count <= Count_Next;
   end

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache miss refill controller: one word per miss from main memory.
// Optional perf counters built when REFILL_PERF_CNT_EN is defined.
module icache_refill_ctrl
   import icache_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int LAT_W  = DEF_LAT_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              Miss_Req,
   input  logic [ADDR_W-1:0] Miss_Addr,
   output logic              Access_MM,
   output logic [DATA_W-1:0] Data_MM,
   output logic              MM_Valid,
   output logic [ADDR_W-1:0] Fill_Addr,
   output logic              Stall,
   output logic              Mem_Rd_En,
   output logic [ADDR_W-1:0] Mem_Addr,
   input  logic [DATA_W-1:0] Mem_Rd_Data,
   input  logic              Mem_Ready,
   output logic [LAT_W-1:0]  Last_Latency,
   output logic [CNT_W-1:0]  CNT_REFILL,
   output logic [CNT_W-1:0]  CNT_STALL
);

   localparam logic [ADDR_W-1:0] ALIGN_MASK =
      ~ADDR_W'((1 << WORD_OFS) - 1);

   state_t           state;
   state_t           state_nxt;
   logic             miss_take;
   logic             mem_take;
   logic [LAT_W-1:0] lat_next;

   assign miss_take = (state == IDLE) && Miss_Req;
   assign mem_take  = (state == WAIT) && Mem_Ready;
   assign Stall     = Miss_Req || (state != IDLE);
   assign Mem_Addr  = Fill_Addr;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Miss_Req) state_nxt = REQ;
         REQ:     state_nxt = WAIT;
         WAIT:    if (Mem_Ready) state_nxt = FILL;
         FILL:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   sat_counter #(.W(LAT_W)) u_lat (
      .CLK        (CLK),
      .RESET      (RESET),
      .Clr        (miss_take),
      .Inc        (state == WAIT),
      .Count_Next (lat_next)
   );

   // Strobes are flopped from the next state so they line up with it.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state        <= IDLE;
         Access_MM    <= 1'b0;
         MM_Valid     <= 1'b0;
         Mem_Rd_En    <= 1'b0;
         Data_MM      <= '0;
         Fill_Addr    <= '0;
         Last_Latency <= '0;
      end else begin
         state     <= state_nxt;
         Access_MM <= (state_nxt != IDLE);
         MM_Valid  <= (state_nxt == FILL);
         Mem_Rd_En <= (state_nxt == REQ);
         if (miss_take)
            Fill_Addr <= Miss_Addr & ALIGN_MASK;
         if (mem_take) begin
            Data_MM      <= Mem_Rd_Data;
            Last_Latency <= lat_next;
         end
      end
   end

`ifdef REFILL_PERF_CNT_EN
   logic [CNT_W-1:0] cnt_refill;
   logic [CNT_W-1:0] cnt_stall;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt_refill <= '0;
         cnt_stall  <= '0;
      end else begin
         if (state == FILL)
            cnt_refill <= cnt_refill + CNT_W'(1);
         if (Stall)
            cnt_stall <= cnt_stall + CNT_W'(1);
      end
   end

   assign CNT_REFILL = cnt_refill;
   assign CNT_STALL  = cnt_stall;
`else
   assign CNT_REFILL = '0;
   assign CNT_STALL  = '0;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: vector table,
// directed corner sequences and randomized refill transactions.
module tb_icache_refill_ctrl;

   logic        CLK;
   logic        RESET;
   logic        Miss_Req;
   logic [31:0] Miss_Addr;
   logic        Access_MM;
   logic [31:0] Data_MM;
   logic        MM_Valid;
   logic [31:0] Fill_Addr;
   logic        Stall;
   logic        Mem_Rd_En;
   logic [31:0] Mem_Addr;
   logic [31:0] Mem_Rd_Data;
   logic        Mem_Ready;
   logic [7:0]  Last_Latency;
   logic [19:0] CNT_REFILL;
   logic [19:0] CNT_STALL;

   int checks = 0;
   int errors = 0;
   logic [31:0] model_data;

   icache_refill_ctrl dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .Miss_Req     (Miss_Req),
      .Miss_Addr    (Miss_Addr),
      .Access_MM    (Access_MM),
      .Data_MM      (Data_MM),
      .MM_Valid     (MM_Valid),
      .Fill_Addr    (Fill_Addr),
      .Stall        (Stall),
      .Mem_Rd_En    (Mem_Rd_En),
      .Mem_Addr     (Mem_Addr),
      .Mem_Rd_Data  (Mem_Rd_Data),
      .Mem_Ready    (Mem_Ready),
      .Last_Latency (Last_Latency),
      .CNT_REFILL   (CNT_REFILL),
      .CNT_STALL    (CNT_STALL)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          lat;
      bit          noise;
      logic [31:0] exp_fill;
      int          exp_lat;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One miss transaction; memory answers lat cycles after the request.
   task automatic refill(input logic [31:0] addr, input logic [31:0] data,
                         input int lat, input bit noise,
                         input logic [31:0] exp_fill, input int exp_lat);
      int rd_n = 0, rd_c = -1, vl_n = 0, vl_c = -1;
      int acc_bad = 0, stall_bad = 0, fill_bad = 0;
      logic [31:0] rd_addr = '0, vl_data = '0;
      logic [7:0]  vl_lat = '0;
      for (int c = 0; c <= lat + 2; c++) begin
         @(negedge CLK);
         if (c == 0) begin
            Miss_Req  = 1'b1;
            Miss_Addr = addr;
         end else begin
            Miss_Req  = noise ? 1'($urandom % 2) : 1'b0;
            Miss_Addr = 32'h40;
         end
         Mem_Ready = (c == lat + 1) ||
                     (noise && (c == 1 || c == lat + 2) && ($urandom % 2 == 1));
         Mem_Rd_Data = (c == lat + 1) ? data : $urandom;
         #1;
         if (Mem_Rd_En) begin rd_n++; rd_c = c; rd_addr = Mem_Addr; end
         if (MM_Valid) begin
            vl_n++; vl_c = c; vl_data = Data_MM; vl_lat = Last_Latency;
         end
         if (Access_MM !== (c != 0)) acc_bad++;
         if (Stall !== 1'b1) stall_bad++;
         if (c > 0 && (Fill_Addr !== exp_fill || Mem_Addr !== Fill_Addr))
            fill_bad++;
      end
      chk("rd_en_count", rd_n, 1);
      chk("rd_en_cycle", rd_c, 1);
      chk("mem_addr", rd_addr, exp_fill);
      chk("mm_valid_count", vl_n, 1);
      chk("mm_valid_cycle", vl_c, lat + 2);
      chk("data_mm", vl_data, data);
      chk("last_latency", vl_lat, exp_lat);
      chk("access_mm_window", acc_bad, 0);
      chk("stall_window", stall_bad, 0);
      chk("fill_addr_hold", fill_bad, 0);
      model_data = data;
   endtask

   task automatic idle(input int n, input bit spurious);
      int bad = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge CLK);
         Miss_Req    = 1'b0;
         Mem_Ready   = spurious ? 1'($urandom % 2) : 1'b0;
         Mem_Rd_Data = $urandom;
         #1;
         if (Access_MM !== 1'b0 || MM_Valid !== 1'b0 ||
             Mem_Rd_En !== 1'b0 || Stall !== 1'b0 ||
             Data_MM !== model_data)
            bad++;
      end
      chk("idle_quiet", bad, 0);
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{32'h0000_1236, 32'hDEAD_BEEF, 1, 1'b0, 32'h0000_1234, 1};
      vecs[1] = '{32'h0000_2000, 32'h1111_2222, 7, 1'b0, 32'h0000_2000, 7};
      vecs[2] = '{32'h0000_3003, 32'hCAFE_F00D, 300, 1'b0, 32'h0000_3000, 255};
      vecs[3] = '{32'hFFFF_FFFF, 32'h0BAD_CAFE, 2, 1'b1, 32'hFFFF_FFFC, 2};
      vecs[4] = '{32'h0000_0101, 32'h5555_AAAA, 255, 1'b0, 32'h0000_0100, 255};
      vecs[5] = '{32'h0000_0202, 32'hA5A5_5A5A, 254, 1'b0, 32'h0000_0200, 254};
      vecs[6] = '{32'h8000_0007, 32'h0123_4567, 5, 1'b1, 32'h8000_0004, 5};

      RESET = 1'b1; Miss_Req = 1'b0; Miss_Addr = '0;
      Mem_Ready = 1'b0; Mem_Rd_Data = '0;
      model_data = '0;
      @(negedge CLK);
      @(negedge CLK);
      Mem_Ready = 1'b1; Mem_Rd_Data = 32'hFFFF_0000;
      #1;
      chk("rst_access", Access_MM, 0);
      chk("rst_valid", MM_Valid, 0);
      chk("rst_rd_en", Mem_Rd_En, 0);
      chk("rst_data", Data_MM, 0);
      chk("rst_fill", Fill_Addr, 0);
      chk("rst_lat", Last_Latency, 0);
      chk("rst_stall", Stall, 0);
      chk("rst_cnt_refill", CNT_REFILL, 0);
      chk("rst_cnt_stall", CNT_STALL, 0);
      @(negedge CLK);
      RESET = 1'b0; Mem_Ready = 1'b0;

      idle(3, 1'b1);
      foreach (vecs[i]) begin
         refill(vecs[i].addr, vecs[i].data, vecs[i].lat, vecs[i].noise,
                vecs[i].exp_fill, vecs[i].exp_lat);
         idle(2, 1'b1);
      end

      // Reset while waiting on memory, then a late ready.
      @(negedge CLK);
      Miss_Req = 1'b1; Miss_Addr = 32'h0000_2000; Mem_Ready = 1'b0;
      @(negedge CLK);
      Miss_Req = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      #1;
      chk("pre_reset_busy", Access_MM, 1);
      @(negedge CLK);
      RESET = 1'b0; Mem_Ready = 1'b1; Mem_Rd_Data = 32'h1234_5678;
      #1;
      chk("abort_access", Access_MM, 0);
      chk("abort_valid", MM_Valid, 0);
      chk("abort_data", Data_MM, 0);
      chk("abort_fill", Fill_Addr, 0);
      chk("abort_lat", Last_Latency, 0);
      chk("abort_stall", Stall, 0);
      @(negedge CLK);
      Mem_Ready = 1'b0;
      #1;
      chk("late_ready_valid", MM_Valid, 0);
      chk("late_ready_rd_en", Mem_Rd_En, 0);
      chk("late_ready_access", Access_MM, 0);
      chk("late_ready_data", Data_MM, 0);
      model_data = '0;

      // Three back-to-back refills at minimum memory latency.
      refill(32'h0000_0010, 32'h0000_0001, 1, 1'b0, 32'h0000_0010, 1);
      refill(32'h0000_0015, 32'h0000_0002, 1, 1'b0, 32'h0000_0014, 1);
      refill(32'h0000_001A, 32'h0000_0003, 1, 1'b0, 32'h0000_0018, 1);
      @(negedge CLK);
      Miss_Req = 1'b0; Mem_Ready = 1'b0;
      #1;
`ifdef REFILL_PERF_CNT_EN
      chk("cnt_refill", CNT_REFILL, 3);
      chk("cnt_stall", CNT_STALL, 12);
`else
      chk("cnt_refill_off", CNT_REFILL, 0);
      chk("cnt_stall_off", CNT_STALL, 0);
`endif

      for (int k = 0; k < 25; k++) begin
         logic [31:0] a, d;
         int l;
         bit nz;
         a  = $urandom;
         d  = $urandom;
         l  = $urandom_range(1, 12);
         nz = 1'($urandom % 2);
         refill(a, d, l, nz, {a[31:2], 2'b00}, (l > 255) ? 255 : l);
         if ($urandom % 2 == 1)
            idle($urandom_range(1, 3), 1'b1);
      end
      idle(2, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
